bus_router_n: RTL and testbench

//  Parametrised single-master data-bus router between the CPU load/store port and N_SLV slaves
//  (data memory, MMIO devices, ...). Decodes each request by base/mask region and forwards it to
//  one slave. Uses a req/gnt + rvalid handshake with one outstanding transaction. Returns a decode

---
 rtl/bus_router_n.sv | 156 +++++++++++++++
 tb/tb_bus_router_n.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_router_n.sv
// Single-master load/store router: base/mask decode onto N_SLV slaves, one transaction in flight, decode-error response.
// Latency: slv_req the cycle after accept, cpu_rvalid the cycle after slave rvalid; unmapped requests answer the cycle after accept.
// Backpressure: cpu_gnt only while idle, so the CPU holds cpu_req; the optional abort timer is ROUTER_TIMEOUT_EN.
module bus_router_n #(
    parameter int                  N_SLV    = 2,
    parameter int                  AW       = 32,
    parameter int                  DW       = 32,
    parameter logic [N_SLV*AW-1:0] SLV_BASE = {32'hA000_0000, 32'h0000_0000},
    parameter logic [N_SLV*AW-1:0] SLV_MASK = {32'hE000_0000, 32'h0000_0000},
    parameter int                  TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [AW-1:0]       cpu_addr,
    input  logic [DW-1:0]       cpu_wdata,
    input  logic [DW/8-1:0]     cpu_wstrb,
    output logic                cpu_gnt,
    output logic                cpu_rvalid,
    output logic [DW-1:0]       cpu_rdata,
    output logic                cpu_err,
    output logic [N_SLV-1:0]    slv_req,
    output logic                slv_we,
    output logic [AW-1:0]       slv_addr,
    output logic [DW-1:0]       slv_wdata,
    output logic [DW/8-1:0]     slv_wstrb,
    input  logic [N_SLV-1:0]    slv_gnt,
    input  logic [N_SLV-1:0]    slv_rvalid,
    input  logic [N_SLV*DW-1:0] slv_rdata
);

    localparam int IW = (N_SLV > 1) ? $clog2(N_SLV) : 1;

    if (N_SLV < 1 || N_SLV > 8 || (DW % 8) != 0 || TIMEOUT < 1) begin : g_param_check
        $error("bus_router_n: illegal parameter set");
    end

    typedef enum logic [1:0] {IDLE, REQ, RSP, ERR} state_t;

    typedef struct packed {
        logic            we;
        logic [AW-1:0]   addr;
        logic [DW-1:0]   wdata;
        logic [DW/8-1:0] wstrb;
    } req_t;

    state_t        state;
    req_t          req_q;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] dec_idx;
    logic          dec_hit;
    logic          sel_gnt;
    logic          sel_rvalid;
    logic [DW-1:0] sel_rdata;
    logic          done;
    logic          tmo_hit;

    // Ascending scan so the highest-index matching region wins.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if ((cpu_addr & SLV_MASK[i*AW +: AW]) == (SLV_BASE[i*AW +: AW] & SLV_MASK[i*AW +: AW])) begin
                dec_hit = 1'b1;
                dec_idx = IW'(i);
            end
        end
    end

    assign cpu_gnt    = (state == IDLE) & cpu_req;
    assign sel_gnt    = slv_gnt[idx_q];
    assign sel_rvalid = slv_rvalid[idx_q];
    assign sel_rdata  = slv_rdata[idx_q*DW +: DW];
    assign done       = ((state == REQ) & sel_gnt & sel_rvalid) | ((state == RSP) & sel_rvalid);

    assign slv_we    = req_q.we;
    assign slv_addr  = req_q.addr;
    assign slv_wdata = req_q.wdata;
    assign slv_wstrb = req_q.wstrb;

`ifdef ROUTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] tmo_cnt;

    assign tmo_hit = ((state == REQ) || (state == RSP)) && (tmo_cnt == CW'(TIMEOUT));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tmo_cnt <= '0;
        end else if ((state == REQ) || (state == RSP)) begin
            if (!tmo_hit) tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            req_q      <= '0;
            idx_q      <= '0;
            slv_req    <= '0;
            cpu_rvalid <= 1'b0;
            cpu_err    <= 1'b0;
            cpu_rdata  <= '0;
        end else begin
            cpu_rvalid <= 1'b0;
            cpu_err    <= 1'b0;
            cpu_rdata  <= '0;
            unique case (state)
                IDLE: begin
                    if (cpu_req) begin
                        req_q <= '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata, wstrb: cpu_wstrb};
                        idx_q <= dec_idx;
                        if (dec_hit) begin
                            slv_req <= N_SLV'(1) << dec_idx;
                            state   <= REQ;
                        end else begin
                            cpu_rvalid <= 1'b1;
                            cpu_err    <= 1'b1;
                            state      <= ERR;
                        end
                    end
                end
                REQ, RSP: begin
                    // A completion in the same cycle as the timer limit still counts as success.
                    if (done) begin
                        slv_req    <= '0;
                        cpu_rvalid <= 1'b1;
                        cpu_rdata  <= req_q.we ? '0 : sel_rdata;
                        state      <= IDLE;
                    end else if (tmo_hit) begin
                        slv_req    <= '0;
                        cpu_rvalid <= 1'b1;
                        cpu_err    <= 1'b1;
                        state      <= IDLE;
                    end else if ((state == REQ) && sel_gnt) begin
                        slv_req <= '0;
                        state   <= RSP;
                    end
                end
                ERR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_router_n.sv
// Randomised bench for bus_router_n against a decode/latency reference model; timeout scenario under ROUTER_TIMEOUT_EN.
module tb_bus_router_n;

    localparam int N_SLV = 2;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int SW    = DW / 8;
    localparam logic [N_SLV*AW-1:0] BASE    = {32'hA000_0000, 32'h0000_0000};
    localparam logic [N_SLV*AW-1:0] MASK    = {32'hE000_0000, 32'h0000_0000};
    localparam logic [N_SLV*AW-1:0] MASK_NC = {32'hE000_0000, 32'hF000_0000};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                resetn;
    logic                cpu_req, cpu_we;
    logic [AW-1:0]       cpu_addr;
    logic [DW-1:0]       cpu_wdata;
    logic [SW-1:0]       cpu_wstrb;
    logic                cpu_gnt, cpu_rvalid, cpu_err;
    logic [DW-1:0]       cpu_rdata;
    logic [N_SLV-1:0]    slv_req, slv_gnt, slv_rvalid;
    logic                slv_we;
    logic [AW-1:0]       slv_addr;
    logic [DW-1:0]       slv_wdata;
    logic [SW-1:0]       slv_wstrb;
    logic [N_SLV*DW-1:0] slv_rdata;

    logic                nc_req;
    logic [AW-1:0]       nc_addr;
    logic                nc_gnt, nc_rvalid, nc_err;
    logic [DW-1:0]       nc_rdata;
    logic [N_SLV-1:0]    nc_slv_req;
    logic                nc_slv_we;
    logic [AW-1:0]       nc_slv_addr;
    logic [DW-1:0]       nc_slv_wdata;
    logic [SW-1:0]       nc_slv_wstrb;
    logic [N_SLV-1:0]    nc_zero_n = '0;
    logic [N_SLV*DW-1:0] nc_zero_d = '0;

    int n_pass  = 0;
    int n_total = 0;

    bus_router_n #(.N_SLV(N_SLV), .AW(AW), .DW(DW), .SLV_BASE(BASE), .SLV_MASK(MASK), .TIMEOUT(8)) dut (
        .clk(clk), .resetn(resetn),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .slv_req(slv_req), .slv_we(slv_we), .slv_addr(slv_addr), .slv_wdata(slv_wdata), .slv_wstrb(slv_wstrb),
        .slv_gnt(slv_gnt), .slv_rvalid(slv_rvalid), .slv_rdata(slv_rdata)
    );

    bus_router_n #(.N_SLV(N_SLV), .AW(AW), .DW(DW), .SLV_BASE(BASE), .SLV_MASK(MASK_NC), .TIMEOUT(8)) dut_nc (
        .clk(clk), .resetn(resetn),
        .cpu_req(nc_req), .cpu_we(cpu_we), .cpu_addr(nc_addr), .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
        .cpu_gnt(nc_gnt), .cpu_rvalid(nc_rvalid), .cpu_rdata(nc_rdata), .cpu_err(nc_err),
        .slv_req(nc_slv_req), .slv_we(nc_slv_we), .slv_addr(nc_slv_addr), .slv_wdata(nc_slv_wdata), .slv_wstrb(nc_slv_wstrb),
        .slv_gnt(nc_zero_n), .slv_rvalid(nc_zero_n), .slv_rdata(nc_zero_d)
    );

    // Reference decode: index of the highest matching region, -1 when unmapped.
    function automatic int ref_decode(input logic [AW-1:0] a, input logic [N_SLV*AW-1:0] b,
                                      input logic [N_SLV*AW-1:0] m);
        int hit;
        hit = -1;
        for (int i = 0; i < N_SLV; i++)
            if ((a & m[i*AW +: AW]) == (b[i*AW +: AW] & m[i*AW +: AW])) hit = i;
        return hit;
    endfunction

    // Observations gathered by run_txn.
    logic             o_acc, o_we, o_err;
    logic [AW-1:0]    o_addr;
    logic [DW-1:0]    o_wdata, o_rdata;
    logic [SW-1:0]    o_wstrb;
    logic [N_SLV-1:0] o_req0;
    int               o_req_bad, o_gnt_bad, o_rv_cnt, o_rv_k;

    // Drives one transaction; the slave grants at cycle g after slv_req rises and responds d cycles later.
    task automatic run_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input logic [SW-1:0] wstrb, input int g, input int d, input logic [DW-1:0] rval,
                           input bit noise, input bit toggle, input int extra);
        int               tgt, krsp;
        logic [N_SLV-1:0] oh, exp_req;
        tgt  = ref_decode(addr, BASE, MASK);
        oh   = N_SLV'(1) << tgt;
        krsp = g + d + 1;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_wstrb = wstrb;
        #1 o_acc = cpu_gnt;
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_we = 1'($urandom); cpu_addr = $urandom; cpu_wdata = $urandom; cpu_wstrb = SW'($urandom);
        o_req_bad = 0; o_gnt_bad = 0; o_rv_cnt = 0; o_rv_k = -1; o_rdata = 'x; o_err = 1'bx;
        for (int k = 0; k <= krsp; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            slv_gnt    = noise ? (N_SLV'($urandom) & ~oh) : '0;
            slv_rvalid = noise ? (N_SLV'($urandom) & ~oh) : '0;
            if (k == g)     slv_gnt    = slv_gnt | oh;
            if (k == g + d) slv_rvalid = slv_rvalid | oh;
            for (int s = 0; s < N_SLV; s++) slv_rdata[s*DW +: DW] = $urandom;
            if (k == g + d) slv_rdata[tgt*DW +: DW] = rval;
            cpu_req = (toggle && k < krsp) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            exp_req = (k <= g) ? oh : '0;
            if (slv_req !== exp_req) o_req_bad++;
            if (cpu_gnt !== 1'b0) o_gnt_bad++;
            if (k == 0) begin
                o_req0 = slv_req; o_we = slv_we; o_addr = slv_addr; o_wdata = slv_wdata; o_wstrb = slv_wstrb;
            end
            if (cpu_rvalid === 1'b1) begin
                o_rv_cnt++; o_rv_k = k; o_rdata = cpu_rdata; o_err = cpu_err;
            end
        end
        for (int j = 0; j < extra; j++) begin
            @(posedge clk); #1;
            slv_gnt = '0; slv_rvalid = '0;
            @(negedge clk);
            if (cpu_rvalid !== 1'b0) o_rv_cnt++;
        end
    endtask

    task automatic test_reset;
        logic [2+DW+N_SLV+1+AW+DW+SW-1:0] v;
        resetn = 1'b1;
        #2 resetn = 1'b0;
        #1;
        v = {cpu_rvalid, cpu_err, cpu_rdata, slv_req, slv_we, slv_addr, slv_wdata, slv_wstrb};
        n_total++;
        if (v !== '0 || cpu_gnt !== 1'b0) $display("FAIL reset_outputs: got %h gnt %b, want 0", v, cpu_gnt);
        else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_total++;
        if (cpu_rvalid !== 1'b0 || slv_req !== '0 || nc_rvalid !== 1'b0 || nc_slv_req !== '0)
            $display("FAIL reset_held: rvalid %b req %b nc_rvalid %b nc_req %b, want 0", cpu_rvalid, slv_req, nc_rvalid, nc_slv_req);
        else n_pass++;
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_read_mem;
        run_txn(1'b0, 32'h0000_1000, 32'h0, 4'h0, 0, 1, 32'h1234_5678, 1'b0, 1'b0, 2);
        n_total++; if (o_acc !== 1'b1) $display("FAIL rd_gnt: got %b want 1", o_acc); else n_pass++;
        n_total++; if (o_req0 !== 2'b01) $display("FAIL rd_slv_req: got %b want 01", o_req0); else n_pass++;
        n_total++; if (o_addr !== 32'h0000_1000 || o_we !== 1'b0) $display("FAIL rd_bus: got %h/%b want 00001000/0", o_addr, o_we); else n_pass++;
        n_total++; if (o_rv_cnt !== 1 || o_rv_k !== 2) $display("FAIL rd_latency: got cnt %0d k %0d want 1/2", o_rv_cnt, o_rv_k); else n_pass++;
        n_total++; if (o_rdata !== 32'h1234_5678 || o_err !== 1'b0) $display("FAIL rd_data: got %h err %b want 12345678/0", o_rdata, o_err); else n_pass++;
    endtask

    task automatic test_write_mmio;
        run_txn(1'b1, 32'hA000_0010, 32'hDEAD_BEEF, 4'b0011, 1, 2, 32'hFFFF_FFFF, 1'b0, 1'b0, 2);
        n_total++; if (o_acc !== 1'b1) $display("FAIL wr_gnt: got %b want 1", o_acc); else n_pass++;
        n_total++; if (o_req0 !== 2'b10 || o_req_bad !== 0) $display("FAIL wr_slv_req: got %b bad %0d want 10/0", o_req0, o_req_bad); else n_pass++;
        n_total++;
        if (o_we !== 1'b1 || o_addr !== 32'hA000_0010 || o_wdata !== 32'hDEAD_BEEF || o_wstrb !== 4'b0011)
            $display("FAIL wr_bus: got %b %h %h %b want 1 a0000010 deadbeef 0011", o_we, o_addr, o_wdata, o_wstrb);
        else n_pass++;
        n_total++; if (o_rv_cnt !== 1 || o_rv_k !== 4) $display("FAIL wr_latency: got cnt %0d k %0d want 1/4", o_rv_cnt, o_rv_k); else n_pass++;
        n_total++; if (o_rdata !== 32'h0 || o_err !== 1'b0) $display("FAIL wr_ack: got %h err %b want 0/0", o_rdata, o_err); else n_pass++;
    endtask

    task automatic test_unmapped;
        logic [AW-1:0] a;
        for (int t = 0; t < 6; t++) begin
            a = 32'h5000_0000;
            if (t > 0) begin
                a = $urandom;
                for (int r = 0; r < 200 && ref_decode(a, BASE, MASK_NC) >= 0; r++) a = $urandom;
            end
            nc_req = 1'b1; nc_addr = a; cpu_we = 1'($urandom);
            #1;
            n_total++; if (nc_gnt !== 1'b1) $display("FAIL unm_gnt[%0d]: got %b want 1", t, nc_gnt); else n_pass++;
            @(posedge clk); #1;
            nc_req = 1'b0;
            @(negedge clk);
            n_total++;
            if (nc_rvalid !== 1'b1 || nc_err !== 1'b1 || nc_rdata !== '0 || nc_slv_req !== '0)
                $display("FAIL unm_rsp[%0d] addr %h: got rv %b err %b rd %h req %b want 1 1 0 0", t, a, nc_rvalid, nc_err, nc_rdata, nc_slv_req);
            else n_pass++;
            @(posedge clk); #1;
            @(negedge clk);
            n_total++;
            if (nc_rvalid !== 1'b0 || nc_slv_req !== '0)
                $display("FAIL unm_after[%0d]: got rv %b req %b want 0 0", t, nc_rvalid, nc_slv_req);
            else n_pass++;
        end
    endtask

    task automatic test_stall_hold;
        run_txn(1'b0, 32'hA123_4560, 32'h0, 4'h0, 3, 4, 32'hCAFE_F00D, 1'b1, 1'b1, 3);
        n_total++; if (o_gnt_bad !== 0) $display("FAIL stall_gnt: got %0d grants want 0", o_gnt_bad); else n_pass++;
        n_total++; if (o_req_bad !== 0 || o_req0 !== 2'b10) $display("FAIL stall_req: got bad %0d req0 %b want 0/10", o_req_bad, o_req0); else n_pass++;
        n_total++; if (o_rv_cnt !== 1 || o_rv_k !== 8) $display("FAIL stall_rsp: got cnt %0d k %0d want 1/8", o_rv_cnt, o_rv_k); else n_pass++;
        n_total++; if (o_rdata !== 32'hCAFE_F00D || o_err !== 1'b0) $display("FAIL stall_data: got %h err %b want cafef00d/0", o_rdata, o_err); else n_pass++;
    endtask

    task automatic test_reset_mid;
        int seen;
        logic [2+DW+N_SLV+1+AW+DW+SW-1:0] v;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_2000; cpu_wdata = 32'h55AA_1234; cpu_wstrb = 4'hF;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        slv_gnt = 2'b01; slv_rvalid = '0;
        @(posedge clk); #1;
        slv_gnt = '0;
        n_total++;
        if (slv_we !== 1'b1 || slv_addr !== 32'h0000_2000) $display("FAIL rst_pre: got %b %h want 1 00002000", slv_we, slv_addr);
        else n_pass++;
        #2 resetn = 1'b0;
        #1;
        v = {cpu_rvalid, cpu_err, cpu_rdata, slv_req, slv_we, slv_addr, slv_wdata, slv_wstrb};
        n_total++; if (v !== '0) $display("FAIL rst_mid_outputs: got %h want 0", v); else n_pass++;
        @(negedge clk);
        resetn = 1'b1;
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            slv_rvalid = (k == 0) ? 2'b01 : 2'b00;
            slv_rdata  = {$urandom, $urandom};
            @(negedge clk);
            if (cpu_rvalid !== 1'b0) seen++;
        end
        n_total++; if (seen !== 0) $display("FAIL rst_stale_rvalid: got %0d responses want 0", seen); else n_pass++;
        run_txn(1'b0, 32'h0000_0040, 32'h0, 4'h0, 1, 0, 32'h0BAD_F00D, 1'b0, 1'b0, 1);
        n_total++;
        if (o_acc !== 1'b1 || o_rv_cnt !== 1 || o_rv_k !== 2 || o_rdata !== 32'h0BAD_F00D)
            $display("FAIL rst_recover: got acc %b cnt %0d k %0d rd %h want 1 1 2 0badf00d", o_acc, o_rv_cnt, o_rv_k, o_rdata);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        run_txn(1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, 0, 32'h1111_1111, 1'b0, 1'b0, 0);
        n_total++; if (o_rv_k !== 1 || o_rdata !== 32'h1111_1111) $display("FAIL b2b_first: got k %0d rd %h want 1 11111111", o_rv_k, o_rdata); else n_pass++;
        run_txn(1'b1, 32'hB000_0200, 32'h2222_2222, 4'hC, 0, 0, 32'h3333_3333, 1'b0, 1'b0, 0);
        n_total++; if (o_acc !== 1'b1) $display("FAIL b2b_gnt: got %b want 1", o_acc); else n_pass++;
        n_total++; if (o_req0 !== 2'b10 || o_rv_k !== 1 || o_rdata !== 32'h0) $display("FAIL b2b_second: got req %b k %0d rd %h want 10 1 0", o_req0, o_rv_k, o_rdata); else n_pass++;
        run_txn(1'b0, 32'h0000_0300, 32'h0, 4'h0, 0, 1, 32'h4444_4444, 1'b0, 1'b0, 2);
        n_total++; if (o_acc !== 1'b1 || o_rv_cnt !== 1 || o_rdata !== 32'h4444_4444) $display("FAIL b2b_third: got acc %b cnt %0d rd %h want 1 1 44444444", o_acc, o_rv_cnt, o_rdata); else n_pass++;
    endtask

    task automatic test_random;
        logic             we;
        logic [AW-1:0]    addr;
        logic [DW-1:0]    wd, rv, exp_rd;
        logic [SW-1:0]    ws;
        logic [N_SLV-1:0] exp_oh;
        int               g, d;
        for (int t = 0; t < 30; t++) begin
            we = 1'($urandom); addr = $urandom; wd = $urandom; ws = SW'($urandom); rv = $urandom;
            if ($urandom_range(0, 1) == 1) addr[31:29] = 3'b101;
            g = $urandom_range(0, 3); d = $urandom_range(0, 3);
            exp_oh = N_SLV'(1) << ref_decode(addr, BASE, MASK);
            exp_rd = we ? '0 : rv;
            run_txn(we, addr, wd, ws, g, d, rv, 1'b1, 1'b1, (t % 4 == 3) ? 1 : 0);
            n_total++; if (o_acc !== 1'b1) $display("FAIL rnd_gnt[%0d]: got %b want 1", t, o_acc); else n_pass++;
            n_total++;
            if (o_req0 !== exp_oh || o_req_bad !== 0 || o_gnt_bad !== 0)
                $display("FAIL rnd_req[%0d]: got %b bad %0d gnt %0d want %b 0 0", t, o_req0, o_req_bad, o_gnt_bad, exp_oh);
            else n_pass++;
            n_total++;
            if (o_we !== we || o_addr !== addr || o_wdata !== wd || o_wstrb !== ws)
                $display("FAIL rnd_bus[%0d]: got %b %h %h %h want %b %h %h %h", t, o_we, o_addr, o_wdata, o_wstrb, we, addr, wd, ws);
            else n_pass++;
            n_total++;
            if (o_rv_cnt !== 1 || o_rv_k !== g + d + 1 || o_rdata !== exp_rd || o_err !== 1'b0)
                $display("FAIL rnd_rsp[%0d]: got cnt %0d k %0d rd %h err %b want 1 %0d %h 0", t, o_rv_cnt, o_rv_k, o_rdata, o_err, g + d + 1, exp_rd);
            else n_pass++;
        end
    endtask

`ifdef ROUTER_TIMEOUT_EN
    task automatic test_timeout;
        int first_k, rv_cnt, req_bad;
        logic rsp_err;
        logic [DW-1:0] rsp_rd;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_3000;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        first_k = -1; rv_cnt = 0; req_bad = 0; rsp_err = 1'b0; rsp_rd = 'x;
        for (int k = 0; k < 14; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            slv_gnt = '0;
            slv_rvalid = (k == 11) ? 2'b01 : 2'b00;
            @(negedge clk);
            if (slv_req !== ((k <= 8) ? 2'b01 : 2'b00)) req_bad++;
            if (cpu_rvalid === 1'b1) begin
                rv_cnt++;
                if (first_k < 0) begin first_k = k; rsp_err = cpu_err; rsp_rd = cpu_rdata; end
            end
        end
        n_total++; if (req_bad !== 0) $display("FAIL tmo_req: got %0d bad cycles want 0", req_bad); else n_pass++;
        n_total++; if (first_k !== 9 || rv_cnt !== 1) $display("FAIL tmo_latency: got k %0d cnt %0d want 9 1", first_k, rv_cnt); else n_pass++;
        n_total++; if (rsp_err !== 1'b1 || rsp_rd !== 32'h0) $display("FAIL tmo_rsp: got err %b rd %h want 1 0", rsp_err, rsp_rd); else n_pass++;
        run_txn(1'b0, 32'hA000_0400, 32'h0, 4'h0, 1, 1, 32'h7777_0000, 1'b0, 1'b0, 1);
        n_total++;
        if (o_acc !== 1'b1 || o_rv_k !== 3 || o_rdata !== 32'h7777_0000 || o_err !== 1'b0)
            $display("FAIL tmo_next: got acc %b k %0d rd %h err %b want 1 3 77770000 0", o_acc, o_rv_k, o_rdata, o_err);
        else n_pass++;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
        slv_gnt = '0; slv_rvalid = '0; slv_rdata = '0; nc_req = 1'b0; nc_addr = '0;
        test_reset();
        test_read_mem();
        test_write_mmio();
        test_unmapped();
        test_stall_hold();
        test_back_to_back();
        test_random();
        test_reset_mid();
`ifdef ROUTER_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
